// File: rtl/matrix_scan_scheduler.sv
// matrix_scan_scheduler
//   Sequencer for the 5x7 LED matrix display path. One of the five 7-bit
//   column patterns is strobed onto the matrix in each column slot. The block
//   also owns the display-mode selector. It alternates between the FSM-state
//   image and the water-level bar every FRAMES_PER_VIEW frames, and it only
//   switches on a frame boundary. A change of estado_atual forces the state
//   image at the next frame boundary.
//
// Parameters
//   TICK_DIV         clocks per column slot (>= 2)
//   FRAMES_PER_VIEW  frames shown per view before toggling (>= 1)
//   BLANK_CYCLES     anti-ghost blank clocks per slot (< TICK_DIV)
//
// Optional feature macro: MATRIX_GHOST_BLANK_EN
//   When the macro is defined, each tick loads row_data and forces col_sel
//   to 0. The strobe is applied BLANK_CYCLES clocks later. When the macro is
//   undefined, col_sel switches directly on the tick and there is no blank
//   counter.
//
// Ports
//   clk           in   1  system clock, rising edge
//   reset         in   1  asynchronous, active-high
//   enable        in   1  1 = scan runs, 0 = matrix dark and counters frozen
//   estado_atual  in   2  current FSM state, used for change detection
//   col_4..col_0  in   7  column patterns
//   selector      out  1  1 = state image view, 0 = water-level view
//   col_sel       out  5  one-hot column strobe, active-high
//   row_data      out  7  row drive for the strobed column
//   frame_pulse   out  1  1-clk pulse in the cycle column 4 is loaded
//
// Handshake: there is none. The inputs are sampled level-wise on every
// rising edge, and the outputs are registered.

module matrix_scan_scheduler #(
    parameter int TICK_DIV        = 1000,
    parameter int FRAMES_PER_VIEW = 100,
    parameter int BLANK_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] estado_atual,
    input  logic [6:0] col_4,
    input  logic [6:0] col_3,
    input  logic [6:0] col_2,
    input  logic [6:0] col_1,
    input  logic [6:0] col_0,
    output logic       selector,
    output logic [4:0] col_sel,
    output logic [6:0] row_data,
    output logic       frame_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (FRAMES_PER_VIEW > 1) ? $clog2(FRAMES_PER_VIEW + 1) : 1;

    if (TICK_DIV < 2 || FRAMES_PER_VIEW < 1 || BLANK_CYCLES >= TICK_DIV) begin : g_param_check
        $error("matrix_scan_scheduler: illegal parameter combination");
    end

    typedef enum logic {
        VIEW_WATER = 1'b0,
        VIEW_STATE = 1'b1
    } view_t;

    view_t          view;
    logic [PW-1:0]  prescaler;
    logic [2:0]     idx;
    logic [DW-1:0]  dwell;
    logic           pending;
    logic           primed;
    logic [1:0]     estado_prev;

    logic           tick;
    logic           change;
    logic [6:0]     col_mux;
    logic [4:0]     strobe;

`ifdef MATRIX_GHOST_BLANK_EN
    localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    logic [BW-1:0]  blank_cnt;
    logic [4:0]     strobe_hold;
`endif

    // The view state register is the selector; it doubles as the FSM debug view.
    assign selector = (view == VIEW_STATE);

    assign tick   = (prescaler == PW'(TICK_DIV - 1));
    assign change = primed && (estado_atual != estado_prev);
    assign strobe = 5'b00001 << idx;

    always_comb begin
        col_mux = 7'h00;
        case (idx)
            3'd0:    col_mux = col_0;
            3'd1:    col_mux = col_1;
            3'd2:    col_mux = col_2;
            3'd3:    col_mux = col_3;
            3'd4:    col_mux = col_4;
            default: col_mux = 7'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler   <= '0;
            idx         <= 3'd0;
            col_sel     <= 5'b00000;
            row_data    <= 7'h00;
            view        <= VIEW_STATE;
            frame_pulse <= 1'b0;
            dwell       <= '0;
            pending     <= 1'b0;
            primed      <= 1'b0;
            estado_prev <= 2'b00;
`ifdef MATRIX_GHOST_BLANK_EN
            blank_cnt   <= '0;
            strobe_hold <= 5'b00000;
`endif
        end else begin
            // Change detection runs even while the scan is disabled.
            estado_prev <= estado_atual;
            primed      <= 1'b1;
            if (change) begin
                pending <= 1'b1;
            end

            if (enable) begin
                if (tick) begin
                    prescaler <= '0;
                    row_data  <= col_mux;
`ifdef MATRIX_GHOST_BLANK_EN
                    if (BLANK_CYCLES == 0) begin
                        col_sel <= strobe;
                    end else begin
                        col_sel     <= 5'b00000;
                        strobe_hold <= strobe;
                        blank_cnt   <= BW'(BLANK_CYCLES);
                    end
`else
                    col_sel <= strobe;
`endif
                    idx         <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
                    frame_pulse <= (idx == 3'd4);

                    // Frame boundary: a change seen on this very edge counts as pending,
                    // so that it beats a dwell expiry on the same edge.
                    if (idx == 3'd4) begin
                        if (pending || change) begin
                            view    <= VIEW_STATE;
                            dwell   <= '0;
                            pending <= 1'b0;
                        end else if (dwell == DW'(FRAMES_PER_VIEW - 1)) begin
                            view  <= (view == VIEW_STATE) ? VIEW_WATER : VIEW_STATE;
                            dwell <= '0;
                        end else begin
                            dwell <= dwell + DW'(1);
                        end
                    end
                end else begin
                    prescaler   <= prescaler + PW'(1);
                    frame_pulse <= 1'b0;
`ifdef MATRIX_GHOST_BLANK_EN
                    if (blank_cnt != '0) begin
                        blank_cnt <= blank_cnt - BW'(1);
                        if (blank_cnt == BW'(1)) begin
                            col_sel <= strobe_hold;
                        end
                    end
`endif
                end
            end else begin
                col_sel     <= 5'b00000;
                row_data    <= 7'h00;
                frame_pulse <= 1'b0;
`ifdef MATRIX_GHOST_BLANK_EN
                blank_cnt   <= '0;
`endif
            end
        end
    end

endmodule
